// File: rtl/sw_mode_ctrl_if.sv
// ============================================================================
// Module  : sw_mode_ctrl_if
// Brief   : Button/tick inputs and mode outputs of the stopwatch mode
//           controller. Optional lap_cnt field under SW_LAP_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface sw_mode_ctrl_if;
  logic       det0;
  logic       det1;
  logic       det2;
  logic       ms_tick;
  logic [2:0] state;
  logic       run_en;
  logic       clr;
  logic       lap_cap;
  logic       freeze;
`ifdef SW_LAP_COUNT_EN
  logic [3:0] lap_cnt;
`endif

  modport master (
    output det0, det1, det2, ms_tick,
`ifdef SW_LAP_COUNT_EN
    input  lap_cnt,
`endif
    input  state, run_en, clr, lap_cap, freeze
  );

  modport slave (
    input  det0, det1, det2, ms_tick,
`ifdef SW_LAP_COUNT_EN
    output lap_cnt,
`endif
    output state, run_en, clr, lap_cap, freeze
  );
endinterface

`default_nettype wire

// File: rtl/sw_mode_ctrl.sv
// ============================================================================
// Module  : sw_mode_ctrl
// Brief   : Stopwatch mode controller: run/stop/clear sequencing and timed
//           lap-view freeze. Optional lap counter under SW_LAP_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sw_mode_ctrl #(
  parameter int LAP_HOLD_MS = 3000,
  parameter int HOLD_W      = 12,
  parameter int LAP_MAX     = 15
) (
  input  wire logic     mclk,
  input  wire logic     rst_n,
  sw_mode_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_STOP = 3'd2,
    ST_LAP  = 3'd3
  } state_t;

  localparam int              C_HOLD_LAST_I = (LAP_HOLD_MS > 0) ? LAP_HOLD_MS - 1 : 0;
  localparam logic [HOLD_W-1:0] c_hold_last = C_HOLD_LAST_I[HOLD_W-1:0];
  localparam logic              c_hold_en   = (LAP_HOLD_MS != 0);

  if ((LAP_MAX < 0) || (LAP_MAX > 15) || ((2 ** HOLD_W) <= LAP_HOLD_MS)) begin : g_cfg_check
    $error("sw_mode_ctrl: LAP_MAX must fit 4 bits and 2**HOLD_W must exceed LAP_HOLD_MS");
  end

  state_t            r_state;
  state_t            w_nxt;
  logic              r_run_en;
  logic              r_clr;
  logic              r_lap_cap;
  logic              r_freeze;
  logic [HOLD_W-1:0] r_hold;
  logic              w_clr;
  logic              w_cap;
  logic              w_timeout;

  // Higher-priority events fully shadow lower ones; nothing is queued.
  always_comb begin
    w_nxt     = r_state;
    w_clr     = 1'b0;
    w_cap     = 1'b0;
    w_timeout = c_hold_en && bus.ms_tick && (r_hold == c_hold_last);
    if (bus.det2) begin
      w_nxt = ST_IDLE;
      w_clr = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.det0)      w_nxt = ST_RUN;
          else if (bus.det1) w_clr = 1'b1;
        end
        ST_RUN: begin
          if (bus.det0) begin
            w_nxt = ST_STOP;
          end else if (bus.det1) begin
            w_nxt = ST_LAP;
            w_cap = 1'b1;
          end
        end
        ST_LAP: begin
          if (bus.det0)      w_nxt = ST_STOP;
          else if (bus.det1) w_cap = 1'b1;
          else if (w_timeout) w_nxt = ST_RUN;
        end
        ST_STOP: begin
          if (bus.det0) begin
            w_nxt = ST_RUN;
          end else if (bus.det1) begin
            w_nxt = ST_IDLE;
            w_clr = 1'b1;
          end
        end
        default: begin
          w_nxt = ST_IDLE;
          w_clr = 1'b1;
        end
      endcase
    end
  end

  // Outputs decode from the next state so they move on the same edge as state.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_run_en  <= 1'b0;
      r_clr     <= 1'b0;
      r_lap_cap <= 1'b0;
      r_freeze  <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_nxt;
      r_run_en  <= (w_nxt == ST_RUN) || (w_nxt == ST_LAP);
      r_freeze  <= (w_nxt == ST_LAP);
      r_clr     <= w_clr;
      r_lap_cap <= w_cap;
      if ((w_nxt != ST_LAP) || w_cap) begin
        r_hold <= '0;
      end else if (bus.ms_tick) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  assign bus.state   = r_state;
  assign bus.run_en  = r_run_en;
  assign bus.clr     = r_clr;
  assign bus.lap_cap = r_lap_cap;
  assign bus.freeze  = r_freeze;

`ifdef SW_LAP_COUNT_EN
  localparam logic [3:0] c_lap_max = LAP_MAX[3:0];
  logic [3:0] r_lap_cnt;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap_cnt <= 4'd0;
    end else if (w_clr) begin
      r_lap_cnt <= 4'd0;
    end else if (w_cap && (r_lap_cnt < c_lap_max)) begin
      r_lap_cnt <= r_lap_cnt + 4'd1;
    end
  end

  assign bus.lap_cnt = r_lap_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sw_mode_ctrl.sv
// ============================================================================
// Module  : tb_sw_mode_ctrl
// Brief   : Directed scoreboard bench for sw_mode_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sw_mode_ctrl;

  logic mclk;
  logic rst_n;
  int   total;
  int   bad;

  sw_mode_ctrl_if bus ();

  sw_mode_ctrl #(
    .LAP_HOLD_MS (3000),
    .HOLD_W      (12),
    .LAP_MAX     (15)
  ) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       run_en;
    logic       clr;
    logic       lap_cap;
    logic       freeze;
  } exp_t;

  exp_t  q[$];
  string tq[$];

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".state"},   {1'b0, bus.state},     {1'b0, e.st});
    chk({tag, ".run_en"},  {3'b0, bus.run_en},    {3'b0, e.run_en});
    chk({tag, ".clr"},     {3'b0, bus.clr},       {3'b0, e.clr});
    chk({tag, ".lap_cap"}, {3'b0, bus.lap_cap},   {3'b0, e.lap_cap});
    chk({tag, ".freeze"},  {3'b0, bus.freeze},    {3'b0, e.freeze});
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input logic d0, input logic d1, input logic d2, input logic tk,
                      input logic [2:0] st, input logic ren, input logic c,
                      input logic lc, input logic fz, input string tag);
    exp_t  e;
    string t;
    @(negedge mclk);
    bus.det0    = d0;
    bus.det1    = d1;
    bus.det2    = d2;
    bus.ms_tick = tk;
    q.push_back('{st: st, run_en: ren, clr: c, lap_cap: lc, freeze: fz});
    tq.push_back(tag);
    @(posedge mclk);
    #1;
    e = q.pop_front();
    t = tq.pop_front();
    check_all(t, e);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.det0 = 1'b0; bus.det1 = 1'b0; bus.det2 = 1'b0; bus.ms_tick = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    check_all("reset", '{st: 3'd0, run_en: 1'b0, clr: 1'b0, lap_cap: 1'b0, freeze: 1'b0});
`ifdef SW_LAP_COUNT_EN
    chk("reset.lap_cnt", bus.lap_cnt, 4'd0);
`endif
    @(negedge mclk);
    rst_n = 1'b1;

    // Basic run / stop / clear
    step(1,0,0,0, 3'd1,1,0,0,0, "start");
    step(0,0,0,0, 3'd1,1,0,0,0, "run_hold");
    step(0,0,0,1, 3'd1,1,0,0,0, "run_tick");
    step(1,0,0,0, 3'd2,0,0,0,0, "stop");
    step(0,0,0,1, 3'd2,0,0,0,0, "stop_tick");
    step(0,1,0,0, 3'd0,0,1,0,0, "stop_clear");
    step(0,0,0,0, 3'd0,0,0,0,0, "clr_drop");
    step(0,1,0,0, 3'd0,0,1,0,0, "idle_clear");
    step(0,0,0,0, 3'd0,0,0,0,0, "idle_clr_drop");

    // Lap view with timed auto-return
    step(1,0,0,0, 3'd1,1,0,0,0, "start2");
    step(0,1,0,0, 3'd3,1,0,1,1, "lap");
    step(0,0,0,0, 3'd3,1,0,0,1, "lap_cap_drop");
    for (int i = 0; i < 2999; i++) step(0,0,0,1, 3'd3,1,0,0,1, "lap_hold");
    step(0,0,0,1, 3'd1,1,0,0,0, "lap_timeout");
    step(0,0,0,1, 3'd1,1,0,0,0, "run_after_timeout");

    // det1 coinciding with the timeout tick restarts the hold
    step(0,1,0,0, 3'd3,1,0,1,1, "lap2");
    for (int i = 0; i < 2999; i++) step(0,0,0,1, 3'd3,1,0,0,1, "lap2_hold");
    step(0,1,0,1, 3'd3,1,0,1,1, "recap_at_timeout");
    for (int i = 0; i < 2999; i++) step(0,0,0,1, 3'd3,1,0,0,1, "lap3_hold");
    step(0,0,0,1, 3'd1,1,0,0,0, "lap3_timeout");

    // Event priority
    step(1,1,1,0, 3'd0,0,1,0,0, "all_events");
    step(0,0,0,0, 3'd0,0,0,0,0, "all_events_after");
    step(1,0,0,0, 3'd1,1,0,0,0, "start3");
    step(1,1,0,0, 3'd2,0,0,0,0, "det0_over_det1");
    step(1,0,0,0, 3'd1,1,0,0,0, "resume");
    step(0,1,0,0, 3'd3,1,0,1,1, "lap4");
    step(1,0,0,1, 3'd2,0,0,0,0, "lap_stop");
    step(1,0,0,0, 3'd1,1,0,0,0, "resume2");
    step(0,0,1,0, 3'd0,0,1,0,0, "hard_clear");

    // Repeated laps, lap counter saturation when present
    step(1,0,0,0, 3'd1,1,0,0,0, "start4");
    for (int i = 0; i < 17; i++) step(0,1,0,0, 3'd3,1,0,1,1, "multi_lap");
`ifdef SW_LAP_COUNT_EN
    chk("lap_cnt_sat", bus.lap_cnt, 4'd15);
`endif
    step(0,0,1,0, 3'd0,0,1,0,0, "hard_clear2");
`ifdef SW_LAP_COUNT_EN
    chk("lap_cnt_clr", bus.lap_cnt, 4'd0);
`endif

    // Asynchronous reset mid-LAP
    step(1,0,0,0, 3'd1,1,0,0,0, "start5");
    step(0,1,0,0, 3'd3,1,0,1,1, "lap5");
    for (int i = 0; i < 5; i++) step(0,0,0,1, 3'd3,1,0,0,1, "lap5_hold");
    step(0,0,0,0, 3'd3,1,0,0,1, "lap5_idle");
    @(posedge mclk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", '{st: 3'd0, run_en: 1'b0, clr: 1'b0, lap_cap: 1'b0, freeze: 1'b0});
    @(negedge mclk);
    rst_n = 1'b1;
    step(0,0,0,0, 3'd0,0,0,0,0, "post_reset");
    step(1,0,0,0, 3'd1,1,0,0,0, "post_reset_start");
    step(0,1,0,0, 3'd3,1,0,1,1, "post_reset_lap");

    @(negedge mclk);
    bus.det0 = 1'b0; bus.det1 = 1'b0; bus.det2 = 1'b0; bus.ms_tick = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
